// File: rtl/regs_hp_pkg.sv
// Shared types and constants for the register-file host access port.
// Opcode layout: bit 7 selects write, bits 1:0 carry the register address.
package regs_hp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WR,
    RD,
    RSEND,
    ACKS
  } hp_state_t;

  localparam int OP_WR_BIT   = 7;
  localparam int OP_ADDR_LSB = 0;
  localparam int OP_ADDR_W   = 2;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;

endpackage

// File: rtl/hp_shift_word.sv
// Byte-wide shift register: parallel load or shift right with a byte
// entering at the MS end. Outputs show the word as it will be after this edge.
module hp_shift_word #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         load_i,
  input  logic [N-1:0] load_data_i,
  input  logic         shift_i,
  input  logic [7:0]   byte_i,
  output logic [N-1:0] nxt_word_o,
  output logic [7:0]   nxt_byte_o
);

  logic [N-1:0] word_q, word_d;

  // load wins over shift; a shift drops the LS byte and inserts at the top
  always_comb begin
    word_d = word_q;
    if (load_i) begin
      word_d = load_data_i;
    end else if (shift_i) begin
      word_d = word_q >> 8;
      word_d[N-1 -: 8] = byte_i;
    end
  end

  // word storage
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) word_q <= '0;
    else         word_q <= word_d;
  end

  assign nxt_word_o = word_d;
  assign nxt_byte_o = word_d[7:0];

endmodule

// File: rtl/regs_host_port.sv
// Byte-serial host command port onto the 4 x n register file.
// Define REGS_HP_ZERO_EN to make register 0 read-only zero.
module regs_host_port
  import regs_hp_pkg::*;
#(
  parameter int         n   = 8,
  parameter logic [7:0] ACK = ACK_DEFAULT
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic [7:0]   cmd_data,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  output logic [7:0]   rsp_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         hp_busy,
  output logic         w,
  output logic [1:0]   Waddr,
  output logic [n-1:0] Wdata,
  output logic [1:0]   Raddr,
  input  logic [n-1:0] Rdata
);

  localparam int         NB   = n / 8;
  localparam logic [1:0] LAST = 2'(NB - 1);

  hp_state_t    state_q;
  logic [1:0]   cnt_q;
  logic         cmd_fire, rsp_fire;
  logic [1:0]   op_addr;
  logic         wr_en;
  logic [n-1:0] rd_val;
  logic         sh_load, sh_shift;
  logic [7:0]   sh_byte;
  logic [n-1:0] sh_word;
  logic [7:0]   sh_out;
  logic         unused_op;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign op_addr   = cmd_data[OP_ADDR_LSB +: OP_ADDR_W];
  assign unused_op = ^cmd_data[6:2];

`ifdef REGS_HP_ZERO_EN
  assign wr_en  = (Waddr != 2'd0);
  assign rd_val = (Raddr == 2'd0) ? '0 : Rdata;
`else
  assign wr_en  = 1'b1;
  assign rd_val = Rdata;
`endif

  // shift register: filled from commands in WDATA, drained to host in RSEND
  always_comb begin
    sh_load  = (state_q == RD);
    sh_shift = (state_q == WDATA && cmd_fire) ||
               (state_q == RSEND && rsp_fire);
    sh_byte  = (state_q == WDATA) ? cmd_data : 8'h00;
  end

  hp_shift_word #(.N(n)) u_shift (
    .clk         (clk),
    .nReset      (nReset),
    .load_i      (sh_load),
    .load_data_i (rd_val),
    .shift_i     (sh_shift),
    .byte_i      (sh_byte),
    .nxt_word_o  (sh_word),
    .nxt_byte_o  (sh_out)
  );

  // transaction FSM with all handshake and register-file outputs registered
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      hp_busy   <= 1'b0;
      w         <= 1'b0;
      Waddr     <= '0;
      Raddr     <= '0;
      Wdata     <= '0;
    end else begin
      w <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            cnt_q   <= '0;
            hp_busy <= 1'b1;
            if (cmd_data[OP_WR_BIT]) begin
              Waddr   <= op_addr;
              state_q <= WDATA;
            end else begin
              Raddr     <= op_addr;
              cmd_ready <= 1'b0;
              state_q   <= RD;
            end
          end
        end
        WDATA: begin
          if (cmd_fire) begin
            if (cnt_q == LAST) begin
              cnt_q     <= '0;
              Wdata     <= sh_word;
              w         <= wr_en;
              cmd_ready <= 1'b0;
              state_q   <= WR;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        WR: begin
          rsp_data  <= ACK;
          rsp_valid <= 1'b1;
          state_q   <= ACKS;
        end
        RD: begin
          rsp_data  <= sh_out;
          rsp_valid <= 1'b1;
          cnt_q     <= '0;
          state_q   <= RSEND;
        end
        RSEND: begin
          if (rsp_fire) begin
            if (cnt_q == LAST) begin
              cnt_q     <= '0;
              rsp_valid <= 1'b0;
              cmd_ready <= 1'b1;
              hp_busy   <= 1'b0;
              state_q   <= IDLE;
            end else begin
              cnt_q    <= cnt_q + 2'd1;
              rsp_data <= sh_out;
            end
          end
        end
        ACKS: begin
          if (rsp_fire) begin
            cnt_q     <= '0;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            hp_busy   <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regs_host_port.sv
// Scoreboard bench for regs_host_port at a 16-bit word width.
// Honours REGS_HP_ZERO_EN in its reference model.
module tb_regs_host_port;

  localparam int N  = 16;
  localparam int NB = N / 8;

  logic         clk = 1'b0;
  logic         nReset = 1'b0;
  logic [7:0]   cmd_data = 8'h00;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [7:0]   rsp_data;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         hp_busy;
  logic         w;
  logic [1:0]   Waddr;
  logic [N-1:0] Wdata;
  logic [1:0]   Raddr;
  logic [N-1:0] Rdata;

  regs_host_port #(.n(N)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .hp_busy   (hp_busy),
    .w         (w),
    .Waddr     (Waddr),
    .Wdata     (Wdata),
    .Raddr     (Raddr),
    .Rdata     (Rdata)
  );

  always #5 clk = ~clk;

  // the register file the port drives
  logic [N-1:0] rf [4] = '{default: '0};
  logic         rdata_force = 1'b0;
  always @(posedge clk) if (w) rf[Waddr] <= Wdata;
  assign Rdata = rdata_force ? '1 : rf[Raddr];

  // reference register contents and expectation queues
  logic [N-1:0] ref_rf [4] = '{default: '0};
  logic [7:0]   rq [$];
  logic [N+1:0] wq [$];
  int           checks = 0;
  int           errors = 0;
  bit           hold = 0;
  bit           rnd = 0;
  logic [7:0]   exp_b;
  logic [N+1:0] exp_w;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = !hold && (!rnd || ($urandom_range(2) != 0));
    end
  end

  // monitor: response bytes, write strobes, response-phase controls
  always @(negedge clk) begin
    if (nReset) begin
      if (rsp_valid) begin
        checks++;
        if (cmd_ready || !hp_busy) begin
          errors++;
          $display("FAIL rsp_phase_ctl cmd_ready=%0b hp_busy=%0b required 0/1",
                   cmd_ready, hp_busy);
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got %h required none", rsp_data);
        end else begin
          exp_b = rq.pop_front();
          if (rsp_data !== exp_b) begin
            errors++;
            $display("FAIL rsp_data got %h required %h", rsp_data, exp_b);
          end
        end
      end
      if (w) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL w_unexpected addr=%0d data=%h required none", Waddr, Wdata);
        end else begin
          exp_w = wq.pop_front();
          if ({Waddr, Wdata} !== exp_w) begin
            errors++;
            $display("FAIL w_data got %h required %h", {Waddr, Wdata}, exp_w);
          end
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    logic [N+15:0] got, want;
    got  = {cmd_ready, rsp_valid, hp_busy, w, Waddr, Raddr, Wdata, rsp_data};
    want = {1'b1, 3'b000, 4'h0, {N{1'b0}}, 8'h00};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_%s got %h required %h", tag, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout byte=%h cmd_ready=%0b required 1", b, cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((rq.size() != 0 || wq.size() != 0 || hp_busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 300 || !cmd_ready) begin
      errors++;
      $display("FAIL idle_timeout rq=%0d wq=%0d busy=%0b ready=%0b required 0 0 0 1",
               rq.size(), wq.size(), hp_busy, cmd_ready);
      rq.delete();
      wq.delete();
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [N-1:0] d);
    bit           keep = 1;
    logic [N-1:0] t;
`ifdef REGS_HP_ZERO_EN
    keep = (a != 2'd0);
`endif
    if (keep) begin
      wq.push_back({a, d});
      ref_rf[a] = d;
    end
    rq.push_back(8'hA5);
    send_byte({1'b1, 5'($urandom), a});
    for (int i = 0; i < NB; i++) begin
      t = d >> (8 * i);
      send_byte(t[7:0]);
    end
    checks++;
    if (w !== keep) begin
      errors++;
      $display("FAIL w_latency got %0b required %0b", w, keep);
    end
    @(posedge clk);
    #1;
    checks++;
    if (!rsp_valid || w) begin
      errors++;
      $display("FAIL ack_latency rsp_valid=%0b w=%0b required 1 0", rsp_valid, w);
    end
    wait_idle();
  endtask

  task automatic do_read(input logic [1:0] a, input bit stall);
    logic [N-1:0] v, t;
    logic [7:0]   held;
    v = rdata_force ? '1 : ref_rf[a];
`ifdef REGS_HP_ZERO_EN
    if (a == 2'd0) v = '0;
`endif
    for (int i = 0; i < NB; i++) begin
      t = v >> (8 * i);
      rq.push_back(t[7:0]);
    end
    hold = stall;
    send_byte({1'b0, 5'($urandom), a});
    checks++;
    if (!hp_busy || cmd_ready || Raddr !== a) begin
      errors++;
      $display("FAIL rd_issue busy=%0b ready=%0b Raddr=%0d required 1 0 %0d",
               hp_busy, cmd_ready, Raddr, a);
    end
    @(posedge clk);
    #1;
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rd_latency rsp_valid=%0b required 1", rsp_valid);
    end
    if (stall) begin
      held = rsp_data;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checks++;
        if (!rsp_valid || rsp_data !== held || cmd_ready) begin
          errors++;
          $display("FAIL stall_hold valid=%0b data=%h ready=%0b required 1 %h 0",
                   rsp_valid, rsp_data, cmd_ready, held);
        end
      end
      hold = 0;
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("held");
    nReset = 1'b1;
    @(negedge clk);
    chk_reset("released");

    do_write(2'd3, 16'h005C);
    do_read(2'd3, 0);
    do_write(2'd1, 16'h1234);
    do_read(2'd1, 0);
    do_read(2'd1, 1);

    do_write(2'd2, 16'hBEEF);
    send_byte(8'h82);
    send_byte(8'h77);
    @(negedge clk);
    nReset = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge clk);
    nReset = 1'b1;
    do_read(2'd2, 0);

    do_write(2'd0, '1);
    rdata_force = 1'b1;
    do_read(2'd0, 0);
    rdata_force = 1'b0;

    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 1)
        do_write(2'($urandom), N'($urandom));
      else
        do_read(2'($urandom), ($urandom_range(5) == 0));
    end
    rnd = 0;
    for (int a = 0; a < 4; a++) do_read(2'(a), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
